// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline register: state encoding and occupancy width.
package pipe_pkg;

    localparam int OCC_W = 2;

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// Single payload register with load enable and synchronous reset to RESET_VAL.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= RESET_VAL;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register between adjacent core stages, with flush.
// Define PIPE_SKID_EN to add a skid slot that cuts the out_ready -> in_ready path.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [OCC_W-1:0]  occupancy_o
);

    state_e            state_q, state_d;
    logic              xfer_in, xfer_out;
    logic              main_ld;
    logic [DATA_W-1:0] main_d;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign xfer_in     = in_valid_i & in_ready_o;
    assign xfer_out    = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PIPE_SKID_EN
    logic              skid_ld;
    logic [DATA_W-1:0] skid_q;

    assign in_ready_o = (state_q != ST_SKID) & ~flush_i;

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = in_data_i;
        // Flush only clears the valid state; payload registers keep their contents.
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        state_d = ST_FULL;
                        main_ld = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (xfer_in && xfer_out) begin
                        main_ld = 1'b1;
                    end else if (xfer_in) begin
                        state_d = ST_SKID;
                        skid_ld = 1'b1;
                    end else if (xfer_out) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (xfer_out) begin
                        state_d = ST_FULL;
                        main_ld = 1'b1;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    pipe_skid_slot #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (skid_ld),
        .d_i     (in_data_i),
        .q_o     (skid_q)
    );

    assign occupancy_o = OCC_W'(state_q);
`else
    assign in_ready_o = (~out_valid_o | out_ready_i) & ~flush_i;

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        main_d  = in_data_i;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else if (xfer_in) begin
            // Covers both EMPTY->FULL and the FULL reload on a simultaneous drain.
            state_d = ST_FULL;
            main_ld = 1'b1;
        end else if (xfer_out) begin
            state_d = ST_EMPTY;
        end
    end

    assign occupancy_o = {1'b0, out_valid_o};
`endif

    pipe_skid_slot #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (main_ld),
        .d_i     (main_d),
        .q_o     (out_data_o)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, corner sequences, random vs queue model.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = 32;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic          rst;
        logic          iv;
        logic [DW-1:0] id;
        logic          fl;
        logic          ordy;
        logic          chk_ir;
        logic          e_ir;
        logic          e_ov;
        logic          chk_od;
        logic [DW-1:0] e_od;
        logic [1:0]    e_occ;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W    (DW),
        .RESET_VAL (32'h0)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .occupancy_o (occupancy)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [DW-1:0] id,
                         input logic fl, input logic ordy);
        reset     = r;
        in_valid  = iv;
        in_data   = id;
        flush     = fl;
        out_ready = ordy;
    endtask

    // Drive, optionally check in_ready before the edge, then advance to just after the edge.
    task automatic cyc(input logic r, input logic iv, input logic [DW-1:0] id,
                       input logic fl, input logic ordy, input logic cir, input logic eir,
                       input string nm);
        drive(r, iv, id, fl, ordy);
        #1;
        if (cir) chk({nm, " in_ready"}, {31'b0, in_ready}, {31'b0, eir});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic eov, input logic [1:0] eocc,
                           input logic cod, input logic [DW-1:0] eod);
        chk({nm, " out_valid"}, {31'b0, out_valid}, {31'b0, eov});
        chk({nm, " occupancy"}, {30'b0, occupancy}, {30'b0, eocc});
        if (cod) chk({nm, " out_data"}, out_data, eod);
    endtask

    vec_t     tbl[11];
    logic [DW-1:0] mq[$];

    initial begin
        // rst iv id fl ordy | chk_ir e_ir e_ov chk_od e_od e_occ
        tbl[0]  = '{1'b1, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   2'd0};
        tbl[1]  = '{1'b1, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,   2'd0};
        tbl[2]  = '{1'b0, 1'b1, 32'h100,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 2'd1};
        tbl[3]  = '{1'b0, 1'b1, 32'h104,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h104, 2'd1};
        tbl[4]  = '{1'b0, 1'b1, 32'h108,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h108, 2'd1};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h108, 2'd0};
        tbl[6]  = '{1'b0, 1'b1, 32'h300,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 2'd1};
        tbl[7]  = '{1'b0, 1'b1, 32'h304,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 2'd0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 2'd0};
        tbl[9]  = '{1'b0, 1'b1, 32'h308,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h308, 2'd1};
        tbl[10] = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   2'd0};

        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            cyc(tbl[i].rst, tbl[i].iv, tbl[i].id, tbl[i].fl, tbl[i].ordy,
                tbl[i].chk_ir, tbl[i].e_ir, nm);
            chk_out(nm, tbl[i].e_ov, tbl[i].e_occ, tbl[i].chk_od, tbl[i].e_od);
        end

        // Backpressure: hold out_ready low, then release and expect in-order delivery.
        cyc(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, "bp0");
        chk_out("bp0", 1'b1, 2'd1, 1'b1, 32'h200);
`ifdef PIPE_SKID_EN
        cyc(1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 1'b1, 1'b1, "bp1");
        chk_out("bp1", 1'b1, 2'd2, 1'b1, 32'h200);
        cyc(1'b0, 1'b1, 32'h208, 1'b0, 1'b0, 1'b1, 1'b0, "bp2");
        chk_out("bp2", 1'b1, 2'd2, 1'b1, 32'h200);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, "bp3");
        chk_out("bp3", 1'b1, 2'd1, 1'b1, 32'h204);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, "bp4");
        chk_out("bp4", 1'b0, 2'd0, 1'b1, 32'h204);
        // Flush while two payloads are held.
        cyc(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, "fs0");
        cyc(1'b0, 1'b1, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0, "fs1");
        chk_out("fs1", 1'b1, 2'd2, 1'b1, 32'h400);
        cyc(1'b0, 1'b1, 32'h408, 1'b1, 1'b0, 1'b1, 1'b0, "fs2");
        chk_out("fs2", 1'b0, 2'd0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h40c, 1'b0, 1'b0, 1'b1, 1'b1, "fs3");
        chk_out("fs3", 1'b1, 2'd1, 1'b1, 32'h40c);
        cyc(1'b0, 1'b1, 32'h410, 1'b0, 1'b0, 1'b0, 1'b0, "rs0");
        chk_out("rs0", 1'b1, 2'd2, 1'b1, 32'h40c);
`else
        cyc(1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 1'b1, 1'b0, "bp1");
        chk_out("bp1", 1'b1, 2'd1, 1'b1, 32'h200);
        cyc(1'b0, 1'b1, 32'h204, 1'b0, 1'b1, 1'b1, 1'b1, "bp2");
        chk_out("bp2", 1'b1, 2'd1, 1'b1, 32'h204);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, "bp3");
        chk_out("bp3", 1'b0, 2'd0, 1'b1, 32'h204);
        cyc(1'b0, 1'b1, 32'h40c, 1'b0, 1'b0, 1'b1, 1'b1, "rs0");
        chk_out("rs0", 1'b1, 2'd1, 1'b1, 32'h40c);
`endif
        // Reset while stalled beats a concurrent transfer.
        cyc(1'b1, 1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0, "rs1");
        chk_out("rs1", 1'b0, 2'd0, 1'b1, 32'h0);

        // Random traffic against a bounded FIFO model.
        mq.delete();
        for (int n = 0; n < 600; n++) begin
            logic r, iv, fl, ordy, eir;
            logic [DW-1:0] id;
            r    = ($urandom % 60) == 0;
            fl   = ($urandom % 14) == 0;
            iv   = ($urandom % 4) != 0;
            ordy = ($urandom % 3) != 0;
            id   = $urandom;
            eir  = !fl && ((CAP == 2) ? (mq.size() < 2) : (mq.size() == 0 || ordy));
            drive(r, iv, id, fl, ordy);
            #1;
            chk($sformatf("rnd%0d in_ready", n), {31'b0, in_ready}, {31'b0, eir});
            if (r || fl) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && ordy) void'(mq.pop_front());
                if (iv && eir) mq.push_back(id);
            end
            @(posedge clk);
            #1;
            chk_out($sformatf("rnd%0d", n), mq.size() > 0, 2'(mq.size()),
                    mq.size() > 0 || r, (mq.size() > 0) ? mq[0] : 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
